// File: rtl/spi_pkg.sv
// Shared SPI definitions for the master and the retrofitted slave: mode
// constants, byte width and the transfer state encoding.
package spi_pkg;
  localparam int SPI_BYTE_W = 8;

  localparam logic CPOL      = 1'b0;
  localparam logic CPHA      = 1'b1;
  localparam logic LSB_FIRST = 1'b1;

  typedef logic [2:0] spi_state_t;
  localparam spi_state_t IDLE  = 3'd0;
  localparam spi_state_t LEAD  = 3'd1;
  localparam spi_state_t HIGH  = 3'd2;
  localparam spi_state_t LOW   = 3'd3;
  localparam spi_state_t TRAIL = 3'd4;
endpackage

// File: rtl/spi_sclk_tick.sv
// Half-period counter: tick marks the last clk cycle of each SCLK phase.
module spi_sclk_tick
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = !clear && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear || tick) cnt <= '0;
    else                        cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/spi_master.sv
// SPI master, CPOL=0 / CPHA=1, LSB first: MOSI launched on SCLK rise,
// MISO captured on SCLK fall, one byte per start handshake.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int DATA_WIDTH = SPI_BYTE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  cs,
  output logic                  sclk,
  output logic                  MOSI,
  input  logic                  MISO
);
  localparam logic [2:0] LAST_BIT = 3'(DATA_WIDTH - 1);

  spi_state_t            state;
  logic [DATA_WIDTH-1:0] sh;
  logic [2:0]            bit_cnt;
  logic                  tick;

  spi_sclk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (state == IDLE),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cs      <= 1'b1;
      sclk    <= CPOL;
      MOSI    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      sh      <= '0;
      bit_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (start) begin
            sh    <= tx_data;
            cs    <= 1'b0;
            busy  <= 1'b1;
            state <= LEAD;
          end
        end
        LEAD: if (tick) begin
          state <= HIGH;
          sclk  <= 1'b1;
          MOSI  <= sh[0];
          sh    <= sh >> 1;
        end
        HIGH: if (tick) begin
          // Shifted-out MSB slot collects MISO; after all bits sh is the rx byte
          state              <= LOW;
          sclk               <= 1'b0;
          sh[DATA_WIDTH-1]   <= MISO;
        end
        LOW: if (tick) begin
          if (bit_cnt == LAST_BIT) begin
            state <= TRAIL;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            state   <= HIGH;
            sclk    <= 1'b1;
            MOSI    <= sh[0];
            sh      <= sh >> 1;
          end
        end
        TRAIL: if (tick) begin
          state   <= IDLE;
          cs      <= 1'b1;
          busy    <= 1'b0;
          done    <= 1'b1;
          rx_data <= sh;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master.sv
// Randomized self-checking bench: two masters (CLK_DIV=4 and 1), each in
// loopback or against a behavioural CPHA=1 LSB-first slave.
module tb_spi_master;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset [2];
  logic       start [2];
  logic [7:0] tx    [2];
  logic       busy  [2];
  logic       done  [2];
  logic [7:0] rx    [2];
  logic       cs    [2];
  logic       sclk  [2];
  logic       mosi  [2];
  logic       miso  [2];

  logic       loopback [2];
  logic [7:0] slv_init [2];
  logic [7:0] slv_sh   [2];
  logic [7:0] slv_rx   [2];
  logic       slv_miso [2];
  logic       prev_sclk[2];

  int n_checks = 0;
  int n_pass   = 0;

  spi_master #(.CLK_DIV(4), .DATA_WIDTH(8)) u_dut4 (
    .clk(clk), .reset(reset[0]), .start(start[0]), .tx_data(tx[0]),
    .busy(busy[0]), .done(done[0]), .rx_data(rx[0]), .cs(cs[0]),
    .sclk(sclk[0]), .MOSI(mosi[0]), .MISO(miso[0])
  );

  spi_master #(.CLK_DIV(1), .DATA_WIDTH(8)) u_dut1 (
    .clk(clk), .reset(reset[1]), .start(start[1]), .tx_data(tx[1]),
    .busy(busy[1]), .done(done[1]), .rx_data(rx[1]), .cs(cs[1]),
    .sclk(sclk[1]), .MOSI(mosi[1]), .MISO(miso[1])
  );

  assign miso[0] = loopback[0] ? mosi[0] : slv_miso[0];
  assign miso[1] = loopback[1] ? mosi[1] : slv_miso[1];

  // Slave: shifts its byte out LSB first on each SCLK rise, captures MOSI on each fall
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cs[i]) begin
        slv_sh[i] <= slv_init[i];
      end else begin
        if (sclk[i] && !prev_sclk[i]) begin
          slv_miso[i] <= slv_sh[i][0];
          slv_sh[i]   <= slv_sh[i] >> 1;
        end
        if (!sclk[i] && prev_sclk[i]) slv_rx[i] <= {mosi[i], slv_rx[i][7:1]};
      end
      prev_sclk[i] <= sclk[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One transfer; lat counts cycles from the accepting edge to the done cycle
  task automatic xfer(input int i, input logic [7:0] data, output logic [7:0] mbits,
                      output int cs_low, output int lat, output int done_w);
    logic ps;
    int   nrise;
    mbits = '0; cs_low = 0; lat = -1; done_w = 0; nrise = 0;
    @(negedge clk);
    start[i] = 1'b1;
    tx[i]    = data;
    ps       = sclk[i];
    for (int t = 1; t <= 400; t++) begin
      @(negedge clk);
      if (t == 1) begin
        start[i] = 1'b0;
        tx[i]    = 8'($urandom);
      end
      if (!cs[i]) cs_low++;
      if (sclk[i] && !ps && nrise < 8) begin
        mbits[nrise] = mosi[i];
        nrise++;
      end
      ps = sclk[i];
      if (done[i]) begin
        done_w++;
        if (lat < 0) lat = t;
      end
      if (lat >= 0 && t == lat + 1) break;
    end
  endtask

  task automatic check_reset_state(input int i, input string tag);
    check({tag, "_cs"},   32'(cs[i]),   32'd1);
    check({tag, "_sclk"}, 32'(sclk[i]), 32'd0);
    check({tag, "_mosi"}, 32'(mosi[i]), 32'd0);
    check({tag, "_busy"}, 32'(busy[i]), 32'd0);
    check({tag, "_done"}, 32'(done[i]), 32'd0);
    check({tag, "_rx"},   32'(rx[i]),   32'd0);
  endtask

  initial begin
    logic [7:0] mb, data, rx1, rx2;
    int         csl, lat, dw, div, n_done, gap, falls;
    logic       ps, pcs;

    for (int i = 0; i < 2; i++) begin
      reset[i] = 1'b1; start[i] = 1'b0; tx[i] = '0;
      loopback[i] = 1'b1; slv_init[i] = '0;
    end
    repeat (3) @(negedge clk);
    reset[0] = 1'b0; reset[1] = 1'b0;
    @(negedge clk);
    check_reset_state(0, "rst4");
    check_reset_state(1, "rst1");

    // Loopback, CLK_DIV=4
    xfer(0, 8'hA5, mb, csl, lat, dw);
    check("lb_rx",     32'(rx[0]), 32'hA5);
    check("lb_cs_low", 32'(csl),   32'd72);
    check("lb_lat",    32'(lat),   32'd73);
    check("lb_done_w", 32'(dw),    32'd1);
    check("lb_mosi",   32'(mb),    32'hA5);
    check("lb_busy",   32'(busy[0]), 32'd0);

    // Against the slave
    loopback[0] = 1'b0; slv_init[0] = 8'h3C;
    xfer(0, 8'h81, mb, csl, lat, dw);
    check("slv_rx",    32'(rx[0]),     32'h3C);
    check("slv_got",   32'(slv_rx[0]), 32'h81);

    // CLK_DIV=1, single set bit
    xfer(1, 8'h01, mb, csl, lat, dw);
    check("d1_mosi",   32'(mb),      32'h01);
    check("d1_cs_low", 32'(csl),     32'd18);
    check("d1_lat",    32'(lat),     32'd19);
    check("d1_hold",   32'(mosi[1]), 32'd0);
    check("d1_rx",     32'(rx[1]),   32'h01);

    // Random bytes against the slave on both dividers
    loopback[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 2; i++) begin
        div  = (i == 0) ? 4 : 1;
        data = 8'($urandom);
        slv_init[i] = 8'($urandom);
        xfer(i, data, mb, csl, lat, dw);
        check("rnd_rx",     32'(rx[i]),     32'(slv_init[i]));
        check("rnd_slv",    32'(slv_rx[i]), 32'(data));
        check("rnd_mosi",   32'(mb),        32'(data));
        check("rnd_cs_low", 32'(csl),       32'(18 * div));
        check("rnd_lat",    32'(lat),       32'(18 * div + 1));
        check("rnd_hold",   32'(mosi[i]),   32'(data[7]));
      end
    end

    // Start held high: back-to-back transfers, tx changed while busy
    loopback[0] = 1'b1;
    n_done = 0; gap = 0; rx1 = '0; rx2 = '0;
    @(negedge clk);
    start[0] = 1'b1; tx[0] = 8'h55;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (busy[0] && n_done == 0) tx[0] = 8'hAA;
      if (done[0]) begin
        n_done++;
        if (n_done == 1) rx1 = rx[0];
        else begin
          rx2 = rx[0];
          start[0] = 1'b0;
          break;
        end
      end
      if (n_done == 1 && cs[0]) gap++;
    end
    start[0] = 1'b0;
    check("b2b_n_done", 32'(n_done), 32'd2);
    check("b2b_rx1",    32'(rx1),    32'h55);
    check("b2b_rx2",    32'(rx2),    32'hAA);
    check("b2b_gap",    32'(gap),    32'd1);

    // Start pulses while busy must not launch another transfer
    @(negedge clk);
    start[0] = 1'b1; tx[0] = 8'($urandom);
    @(negedge clk);
    start[0] = 1'b0;
    pcs = cs[0]; n_done = 0; falls = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (done[0]) n_done++;
      if (!cs[0] && pcs) falls++;
      pcs = cs[0];
      start[0] = busy[0] && ($urandom_range(0, 2) == 0);
    end
    start[0] = 1'b0;
    check("busy_n_done", 32'(n_done), 32'd1);
    check("busy_no_cs",  32'(falls),  32'd0);

    // Reset after the 4th SCLK fall
    loopback[0] = 1'b0; slv_init[0] = 8'($urandom);
    @(negedge clk);
    start[0] = 1'b1; tx[0] = 8'($urandom);
    @(negedge clk);
    start[0] = 1'b0;
    ps = sclk[0]; falls = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (ps && !sclk[0]) falls++;
      ps = sclk[0];
      if (falls == 4) break;
    end
    check("mid_falls", 32'(falls), 32'd4);
    reset[0] = 1'b1;
    @(negedge clk);
    reset[0] = 1'b0;
    check_reset_state(0, "mid_rst");
    n_done = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (done[0] || !cs[0]) n_done++;
    end
    check("mid_quiet", 32'(n_done), 32'd0);
    loopback[0] = 1'b1;
    xfer(0, 8'h3C, mb, csl, lat, dw);
    check("post_rx",  32'(rx[0]), 32'h3C);
    check("post_lat", 32'(lat),   32'd73);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
